// File: rtl/alu_if.sv
// Operand/result bundle for the registered ALU.
// The master drives operands and select; the slave returns the registered result and flags.
interface alu_if #(
    parameter int size = 8
);
    logic [size-1:0] a;
    logic [size-1:0] b;
    logic            cin;
    logic [5:0]      sel;
    logic [size-1:0] y;
    logic            cout;
    logic            zero;

    modport master (
        output a, b, cin, sel,
        input  y, cout, zero
    );

    modport slave (
        input  a, b, cin, sel,
        output y, cout, zero
    );
endinterface

// File: rtl/alu.sv
// Single-cycle ALU: combinational core selected by sel, with result, carry and zero
// flag registered on the rising clock edge.
module alu #(
    parameter int size = 8
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    localparam int half = size / 2;

    typedef enum logic [1:0] {
        CLS_XFER  = 2'b00,
        CLS_LOGIC = 2'b01,
        CLS_ARITH = 2'b10,
        CLS_SHIFT = 2'b11
    } op_class_t;

    op_class_t       op_class;
    logic            carry_en;
    logic [2:0]      opcode;
    logic            fill;
    logic            def_c;
    logic            c;
    logic [size-1:0] op_x;
    logic [size-1:0] op_y;
    logic [size:0]   sum;
    logic            lt;
    logic            eq;
    logic            gt;
    logic [size-1:0] next_y;
    logic            next_cout;
    logic [size-1:0] y_q;
    logic            cout_q;
    logic            zero_q;

    assign op_class = op_class_t'(bus.sel[5:4]);
    assign carry_en = bus.sel[3];
    assign opcode   = bus.sel[2:0];
    assign fill     = carry_en ? bus.cin : 1'b0;
    assign lt       = bus.a < bus.b;
    assign eq       = bus.a == bus.b;
    assign gt       = bus.a > bus.b;

    // Every arithmetic form reduces to X + Y + c; the opcode only picks operands and default carry.
    always_comb begin
        op_x  = bus.a;
        op_y  = '0;
        def_c = 1'b0;
        case (opcode)
            3'b000: begin op_x = bus.a;  op_y = bus.b;  def_c = 1'b0; end
            3'b001: begin op_x = bus.a;  op_y = ~bus.b; def_c = 1'b1; end
            3'b010: begin op_x = bus.a;  op_y = '0;     def_c = 1'b1; end
            3'b011: begin op_x = bus.a;  op_y = '1;     def_c = 1'b0; end
            3'b100: begin op_x = bus.b;  op_y = ~bus.a; def_c = 1'b1; end
            3'b101: begin op_x = ~bus.a; op_y = '0;     def_c = 1'b1; end
            3'b110: begin op_x = bus.a;  op_y = bus.a;  def_c = 1'b0; end
            3'b111: begin op_x = bus.b;  op_y = '0;     def_c = 1'b1; end
            default: begin op_x = bus.a; op_y = '0;     def_c = 1'b0; end
        endcase
        c   = carry_en ? bus.cin : def_c;
        sum = {1'b0, op_x} + {1'b0, op_y} + {{size{1'b0}}, c};
    end

    always_comb begin
        next_y    = '0;
        next_cout = 1'b0;
        case (op_class)
            CLS_XFER: begin
                case (opcode)
                    3'b000: next_y = bus.a;
                    3'b001: next_y = bus.b;
                    3'b010: next_y = '0;
                    3'b011: next_y = '1;
                    3'b100: next_y = {{(size-1){1'b0}}, bus.cin};
                    3'b101: next_y = gt ? bus.a : bus.b;
                    3'b110: next_y = lt ? bus.a : bus.b;
                    3'b111: next_y = {{(size-3){1'b0}}, lt, eq, gt};
                    default: next_y = '0;
                endcase
            end
            CLS_LOGIC: begin
                case (opcode)
                    3'b000: next_y = bus.a & bus.b;
                    3'b001: next_y = bus.a | bus.b;
                    3'b010: next_y = bus.a ^ bus.b;
                    3'b011: next_y = ~(bus.a & bus.b);
                    3'b100: next_y = ~(bus.a | bus.b);
                    3'b101: next_y = ~(bus.a ^ bus.b);
                    3'b110: next_y = ~bus.a;
                    3'b111: next_y = ~bus.b;
                    default: next_y = '0;
                endcase
            end
            CLS_ARITH: begin
                next_y    = sum[size-1:0];
                next_cout = sum[size];
            end
            CLS_SHIFT: begin
                case (opcode)
                    3'b000: begin next_y = {bus.a[size-2:0], fill};         next_cout = bus.a[size-1]; end
                    3'b001: begin next_y = {fill, bus.a[size-1:1]};         next_cout = bus.a[0];      end
                    3'b010: begin next_y = {bus.a[size-1], bus.a[size-1:1]}; next_cout = bus.a[0];     end
                    3'b011: begin next_y = {bus.a[size-2:0], bus.a[size-1]}; next_cout = bus.a[size-1]; end
                    3'b100: begin next_y = {bus.a[0], bus.a[size-1:1]};     next_cout = bus.a[0];      end
                    3'b101: next_y = bus.a << bus.b[2:0];
                    3'b110: next_y = bus.a >> bus.b[2:0];
                    3'b111: next_y = {bus.a[half-1:0], bus.a[size-1:half]};
                    default: next_y = '0;
                endcase
            end
            default: next_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            y_q    <= next_y;
            cout_q <= next_cout;
            zero_q <= (next_y == '0);
        end
    end

    assign bus.y    = y_q;
    assign bus.cout = cout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_alu.sv
// Randomized self-checking bench for the 8-bit ALU against an integer reference model,
// plus directed vectors with hand-computed results.
module tb_alu;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_if #(.size(8)) bus ();

    alu #(.size(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer model of the operation table, written directly from the arithmetic rules.
    function automatic void refModel(input int a, input int b, input int cin, input int sel,
                                     output int y, output int co);
        int cls, ce, op, c, f, total;
        cls = (sel >> 4) & 3;
        ce  = (sel >> 3) & 1;
        op  = sel & 7;
        f   = ce ? cin : 0;
        y   = 0;
        co  = 0;
        case (cls)
            0: case (op)
                   0: y = a;
                   1: y = b;
                   2: y = 0;
                   3: y = 255;
                   4: y = cin;
                   5: y = (a > b) ? a : b;
                   6: y = (a < b) ? a : b;
                   default: y = (a < b) * 4 + (a == b) * 2 + (a > b);
               endcase
            1: case (op)
                   0: y = a & b;
                   1: y = a | b;
                   2: y = a ^ b;
                   3: y = 255 - (a & b);
                   4: y = 255 - (a | b);
                   5: y = 255 - (a ^ b);
                   6: y = 255 - a;
                   default: y = 255 - b;
               endcase
            2: begin
                case (op)
                    0: begin c = ce ? cin : 0; total = a + b + c;         end
                    1: begin c = ce ? cin : 1; total = a + (255 - b) + c; end
                    2: begin c = ce ? cin : 1; total = a + c;             end
                    3: begin c = ce ? cin : 0; total = a + 255 + c;       end
                    4: begin c = ce ? cin : 1; total = b + (255 - a) + c; end
                    5: begin c = ce ? cin : 1; total = (255 - a) + c;     end
                    6: begin c = ce ? cin : 0; total = 2 * a + c;         end
                    default: begin c = ce ? cin : 1; total = b + c;       end
                endcase
                y  = total % 256;
                co = total / 256;
            end
            default: case (op)
                   0: begin y = (a * 2 + f) % 256;         co = a / 128; end
                   1: begin y = a / 2 + f * 128;           co = a % 2;   end
                   2: begin y = a / 2 + (a / 128) * 128;   co = a % 2;   end
                   3: begin y = (a * 2) % 256 + a / 128;   co = a / 128; end
                   4: begin y = a / 2 + (a % 2) * 128;     co = a % 2;   end
                   5: y = (a * (1 << (b % 8))) % 256;
                   6: y = a / (1 << (b % 8));
                   default: y = (a % 16) * 16 + a / 16;
               endcase
        endcase
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one operation, let one edge pass, then compare; planY/planCout < 0 skip the constant check.
    task automatic applyStimulus(input int a, input int b, input int cin, input int sel,
                                 input bit doRst, input int planY, input int planCout,
                                 input string tag);
        int expY, expCo, expZ;
        @(negedge clk);
        bus.a   = 8'(a);
        bus.b   = 8'(b);
        bus.cin = cin[0];
        bus.sel = 6'(sel);
        rst     = doRst;
        @(posedge clk);
        #1;
        if (doRst) begin
            expY  = 0;
            expCo = 0;
        end else begin
            refModel(a, b, cin, sel, expY, expCo);
        end
        expZ = (expY == 0) ? 1 : 0;
        checkOutput($sformatf("%s_y", tag),    int'(bus.y),    expY);
        checkOutput($sformatf("%s_cout", tag), int'(bus.cout), expCo);
        checkOutput($sformatf("%s_zero", tag), int'(bus.zero), expZ);
        if (planY >= 0)    checkOutput($sformatf("%s_plan_y", tag),    int'(bus.y),    planY);
        if (planCout >= 0) checkOutput($sformatf("%s_plan_cout", tag), int'(bus.cout), planCout);
    endtask

    initial begin
        int a, b, cin, sel;
        bit doRst;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.a   = '0;
        bus.b   = '0;
        bus.cin = 1'b0;
        bus.sel = '0;

        applyStimulus(45, 34, 0, 6'b00_0_000, 1'b1, 0, 0, "reset1");
        applyStimulus(45, 34, 0, 6'b00_0_000, 1'b1, 0, 0, "reset2");
        applyStimulus(45, 34, 0, 6'b00_0_000, 1'b0, 45, 0, "pass_a");

        applyStimulus(45, 34, 1, 6'b10_1_010, 1'b0, 46, 0, "inc_cin");
        applyStimulus(45, 34, 1, 6'b10_0_010, 1'b0, 46, -1, "inc_def");
        applyStimulus(45, 34, 1, 6'b10_0_101, 1'b0, 211, 0, "neg_a");
        applyStimulus(45, 34, 1, 6'b10_0_001, 1'b0, 11, 1, "sub");
        applyStimulus(200, 100, 0, 6'b10_0_000, 1'b0, 44, 1, "add_wrap");
        applyStimulus(0, 100, 0, 6'b10_0_011, 1'b0, 255, 0, "dec_zero");
        applyStimulus(0, 0, 0, 6'b10_0_000, 1'b0, 0, 0, "add_zero");

        applyStimulus(45, 34, 0, 6'b01_0_101, 1'b0, 240, 0, "xnor");
        applyStimulus(45, 34, 0, 6'b01_0_000, 1'b0, 32, 0, "and");
        applyStimulus(45, 34, 0, 6'b01_0_010, 1'b0, 15, 0, "xor");
        applyStimulus(45, 34, 0, 6'b01_0_110, 1'b0, 210, 0, "not_a");

        applyStimulus(45, 34, 1, 6'b11_0_101, 1'b0, 180, 0, "shl_b");
        applyStimulus(45, 34, 1, 6'b11_1_000, 1'b0, 91, 0, "shl_fill");
        applyStimulus(128, 34, 1, 6'b11_0_010, 1'b0, 192, 0, "sra");
        applyStimulus(45, 34, 1, 6'b00_0_101, 1'b0, 45, 0, "max");
        applyStimulus(45, 34, 1, 6'b00_0_111, 1'b0, 1, 0, "cmp");
        applyStimulus(45, 45, 0, 6'b00_0_111, 1'b0, 2, 0, "cmp_eq");
        applyStimulus(45, 34, 1, 6'b11_0_111, 1'b0, 210, 0, "swap");

        for (int i = 0; i < 64; i++) begin
            applyStimulus(165, 90, i % 2, i, 1'b0, -1, -1, $sformatf("sweep%0d", i));
        end

        for (int i = 0; i < 400; i++) begin
            a     = (i % 7 == 0) ? 0 : ((i % 11 == 0) ? 255 : int'($urandom_range(0, 255)));
            b     = (i % 13 == 0) ? a : int'($urandom_range(0, 255));
            cin   = int'($urandom_range(0, 1));
            sel   = int'($urandom_range(0, 63));
            doRst = ($urandom_range(0, 15) == 0);
            applyStimulus(a, b, cin, sel, doRst, -1, -1, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
